// File: rtl/frame_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : frame_stream_reader
// Reads one frame from a synchronous-read frame buffer and emits it as a
// valid/ready pixel stream with sop/eop and run-time 2^d subsampling.
// Optional build macro FRAME_STREAM_TESTPAT_EN adds a coordinate test pattern.
// Revision : 1.0 - initial release
// ============================================================================
module frame_stream_reader #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int PIX_W      = 12,
    parameter int ADDR_W     = 17,
    parameter int RD_LATENCY = 2,
    parameter int MAX_DECIM  = 2,
    parameter int CONTINUOUS = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        decim,
`ifdef FRAME_STREAM_TESTPAT_EN
    input  logic              test_mode,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pixel,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy,
    output logic              freeze,
    output logic              frame_done
);

    localparam int c_depth    = RD_LATENCY + 2;
    localparam int c_cnt_w    = $clog2(c_depth + 1);
    localparam int c_ptr_w    = $clog2(c_depth);
    localparam int c_col_w    = $clog2(H_RES + 1);
    localparam int c_row_w    = $clog2(V_RES + 1);
    localparam int c_last_idx = c_depth - 1;
    localparam logic [c_cnt_w:0]     c_credit_lim = c_depth[c_cnt_w:0];
    localparam logic [c_ptr_w-1:0]   c_last_ptr   = c_last_idx[c_ptr_w-1:0];
    localparam logic [c_col_w-1:0]   c_h_res      = H_RES[c_col_w-1:0];
    localparam logic [c_row_w-1:0]   c_v_res      = V_RES[c_row_w-1:0];
    localparam logic [ADDR_W-1:0]    c_h_res_addr = H_RES[ADDR_W-1:0];
    localparam logic [1:0]           c_max_decim  = MAX_DECIM[1:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_ABORT  = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [1:0]          r_decim;
    logic [c_col_w-1:0]  r_col, w_col_step;
    logic [c_row_w-1:0]  r_row, w_row_step;
    logic [ADDR_W-1:0]   r_row_base, w_base_step;
    logic                w_col_last, w_row_last, w_first, w_last;

    logic [c_cnt_w-1:0]  r_outstanding, r_fifo_count;
    logic [c_cnt_w:0]    w_inflight;
    logic                w_credit, w_load, w_flush, w_ret, w_push, w_pop;
    logic                w_done_nxt, r_done;

    logic [RD_LATENCY-1:0] r_tag_v, r_tag_sop, r_tag_eop;
    logic [PIX_W-1:0]      w_push_pixel;

    logic [PIX_W+1:0]    r_mem [c_depth];
    logic [c_ptr_w-1:0]  r_wr_ptr, r_rd_ptr;
    logic [PIX_W+1:0]    w_head;

    // Source-pixel stepping: column and row advance by 2^d, base by H_RES*2^d
    assign w_col_step  = c_col_w'(1) << r_decim;
    assign w_row_step  = c_row_w'(1) << r_decim;
    assign w_base_step = c_h_res_addr << r_decim;
    assign w_col_last  = (r_col == c_h_res - w_col_step);
    assign w_row_last  = (r_row == c_v_res - w_row_step);
    assign w_first     = (r_col == '0) && (r_row == '0);
    assign w_last      = w_col_last && w_row_last;
    assign rd_addr     = r_row_base + ADDR_W'(r_col);

    assign w_inflight  = {1'b0, r_outstanding} + {1'b0, r_fifo_count};
    assign w_credit    = (w_inflight < c_credit_lim);
    assign w_ret       = r_tag_v[RD_LATENCY-1];

    assign out_valid   = (r_fifo_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign out_pixel   = out_valid ? w_head[PIX_W-1:0] : '0;
    assign out_eop     = out_valid & w_head[PIX_W];
    assign out_sop     = out_valid & w_head[PIX_W+1];
    assign w_pop       = out_valid & out_ready;

    assign busy        = (r_state != S_IDLE);
    assign freeze      = (r_state != S_IDLE);
    assign frame_done  = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        w_done_nxt  = 1'b0;
        rd_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!abort && (start || (CONTINUOUS != 0))) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    w_flush     = 1'b1;
                    w_state_nxt = S_ABORT;
                end else begin
                    rd_en = w_credit;
                    if (w_credit && w_last) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    w_flush     = 1'b1;
                    w_state_nxt = S_ABORT;
                end else if (w_pop && out_eop) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ABORT: begin
                if (r_outstanding == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_decim    <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else if (w_load) begin
            r_decim    <= (decim > c_max_decim) ? c_max_decim : decim;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else if (rd_en && !w_last) begin
            if (w_col_last) begin
                r_col      <= '0;
                r_row      <= r_row + w_row_step;
                r_row_base <= r_row_base + w_base_step;
            end else begin
                r_col <= r_col + w_col_step;
            end
        end
    end

    // Tags travel alongside the read so each returning word knows its role
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_v       <= '0;
            r_outstanding <= '0;
        end else begin
            r_tag_v[0] <= rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
            end
            r_outstanding <= r_outstanding + c_cnt_w'(rd_en) - c_cnt_w'(w_ret);
        end
    end

    always_ff @(posedge clk) begin
        r_tag_sop[0] <= w_first;
        r_tag_eop[0] <= w_last;
        for (int i = 1; i < RD_LATENCY; i++) begin
            r_tag_sop[i] <= r_tag_sop[i-1];
            r_tag_eop[i] <= r_tag_eop[i-1];
        end
    end

`ifdef FRAME_STREAM_TESTPAT_EN
    logic             r_test_mode;
    logic [15:0]      w_xy;
    logic [PIX_W-1:0] r_tag_pat [RD_LATENCY];

    assign w_xy = {8'(r_row >> r_decim), 8'(r_col >> r_decim)};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_test_mode <= 1'b0;
        end else if (w_load) begin
            r_test_mode <= test_mode;
        end
    end

    always_ff @(posedge clk) begin
        r_tag_pat[0] <= PIX_W'(w_xy);
        for (int i = 1; i < RD_LATENCY; i++) begin
            r_tag_pat[i] <= r_tag_pat[i-1];
        end
    end

    assign w_push_pixel = r_test_mode ? r_tag_pat[RD_LATENCY-1] : rd_data;
`else
    assign w_push_pixel = rd_data;
`endif

    // Returns arriving during or after an abort are dropped
    assign w_push = w_ret && !w_flush && ((r_state == S_STREAM) || (r_state == S_DRAIN));

    function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            r_fifo_count <= r_fifo_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_tag_sop[RD_LATENCY-1], r_tag_eop[RD_LATENCY-1], w_push_pixel};
        end
    end

endmodule
`default_nettype wire
